// File: rtl/phy_jtag_pkg.sv
// rtl/phy_jtag_pkg.sv - shared types, constants and TMS sequencing helpers for the JTAG master
package phy_jtag_pkg;

    localparam int PHY_JTAG_LEN_W  = 6;
    localparam int PHY_JTAG_STEP_W = 7;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SCAN,
        ST_RESP
    } state_t;

    // Preamble TMS bits, bit k is driven during TCK k of the command.
    localparam logic [3:0] TMS_PRE_DR = 4'b0001;
    localparam logic [3:0] TMS_PRE_IR = 4'b0011;
    localparam logic [PHY_JTAG_STEP_W-1:0] PRE_LEN_DR = 7'd3;
    localparam logic [PHY_JTAG_STEP_W-1:0] PRE_LEN_IR = 7'd4;
    localparam logic [PHY_JTAG_STEP_W-1:0] RST_TMS_HIGH = 7'd5;

    function automatic logic [PHY_JTAG_STEP_W-1:0] pre_len(input logic is_ir);
        return is_ir ? PRE_LEN_IR : PRE_LEN_DR;
    endfunction

    function automatic logic [PHY_JTAG_STEP_W-1:0] shift_end(input logic is_ir,
                                                             input logic [PHY_JTAG_LEN_W-1:0] len);
        return pre_len(is_ir) + {1'b0, len};
    endfunction

    function automatic logic tms_at(input logic [PHY_JTAG_STEP_W-1:0] step, input logic is_rst,
                                    input logic is_ir, input logic [PHY_JTAG_LEN_W-1:0] len);
        logic [3:0] pre_bits;
        logic [PHY_JTAG_STEP_W-1:0] sh_end;
        pre_bits = is_ir ? TMS_PRE_IR : TMS_PRE_DR;
        sh_end   = shift_end(is_ir, len);
        if (is_rst)
            return step < RST_TMS_HIGH;
        else if (step < pre_len(is_ir))
            return pre_bits[step[1:0]];
        else if (step < sh_end)
            return step == sh_end - 7'd1;
        else
            return step == sh_end;
    endfunction

    function automatic logic in_shift(input logic [PHY_JTAG_STEP_W-1:0] step, input logic is_rst,
                                      input logic is_ir, input logic [PHY_JTAG_LEN_W-1:0] len);
        return !is_rst && (step >= pre_len(is_ir)) && (step < shift_end(is_ir, len));
    endfunction

    function automatic logic [PHY_JTAG_STEP_W-1:0] last_step(input logic is_rst, input logic is_ir,
                                                             input logic [PHY_JTAG_LEN_W-1:0] len);
        return is_rst ? RST_TMS_HIGH : shift_end(is_ir, len) + 7'd1;
    endfunction

endpackage

// File: rtl/phy_jtag_tck_gen.sv
// rtl/phy_jtag_tck_gen.sv - registered TCK generator with rise/fall strobes marking the toggling clk edge
module phy_jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic en,
    output logic tck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    // Strobes are high in the cycle whose closing edge toggles tck.
    assign rise_stb = en && !tck && (cnt == CNT_LAST);
    assign fall_stb = en &&  tck && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= 8'd0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= 8'd0;
            tck <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt <= 8'd0;
            tck <= !tck;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/phy_jtag_master.sv
// rtl/phy_jtag_master.sv - command-driven JTAG master producing IR/DR scans and TAP resets toward the PHY
module phy_jtag_master
    import phy_jtag_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_is_ir,
    input  logic [PHY_JTAG_LEN_W-1:0] cmd_len,
    input  logic [MAX_LEN-1:0]        cmd_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [MAX_LEN-1:0]        rsp_data,
    output logic                      jtag_intf_i_phy_tck,
    output logic                      jtag_intf_i_phy_tms,
    output logic                      jtag_intf_i_phy_tdi,
    output logic                      jtag_intf_i_phy_trst_n,
    input  logic                      jtag_intf_i_phy_tdo
);

    localparam logic [PHY_JTAG_LEN_W-1:0] LEN_MAX = PHY_JTAG_LEN_W'(MAX_LEN);

    state_t                      state;
    logic [PHY_JTAG_STEP_W-1:0]  step;
    logic                        is_ir_q;
    logic                        is_rst_q;
    logic [PHY_JTAG_LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0]          data_sr;
    logic [MAX_LEN-1:0]          cap;
    logic                        tck_en;
    logic                        rise_stb;
    logic                        fall_stb;
    logic [PHY_JTAG_LEN_W-1:0]   len_clamped;
    logic [PHY_JTAG_STEP_W-1:0]  rsp_shift;
    logic [PHY_JTAG_STEP_W-1:0]  step_nxt;

    assign tck_en      = (state == ST_INIT) || (state == ST_SCAN);
    assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign step_nxt    = step + 7'd1;
    // TDO bits enter at the MSB, so the first captured bit ends up at MAX_LEN-len.
    assign rsp_shift   = PHY_JTAG_STEP_W'(MAX_LEN) - {1'b0, len_q};

    phy_jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .rstb     (rstb),
        .en       (tck_en),
        .tck      (jtag_intf_i_phy_tck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state                  <= ST_INIT;
            step                   <= '0;
            is_ir_q                <= 1'b0;
            is_rst_q               <= 1'b1;
            len_q                  <= '0;
            data_sr                <= '0;
            cap                    <= '0;
            cmd_ready              <= 1'b0;
            rsp_valid              <= 1'b0;
            rsp_data               <= '0;
            jtag_intf_i_phy_tms    <= 1'b1;
            jtag_intf_i_phy_tdi    <= 1'b0;
            jtag_intf_i_phy_trst_n <= 1'b0;
        end else begin
            jtag_intf_i_phy_trst_n <= 1'b1;
            case (state)
                ST_INIT, ST_SCAN: begin
                    if (rise_stb && in_shift(step, is_rst_q, is_ir_q, len_q))
                        cap <= {jtag_intf_i_phy_tdo, cap[MAX_LEN-1:1]};
                    if (fall_stb) begin
                        if (step == last_step(is_rst_q, is_ir_q, len_q)) begin
                            step                <= '0;
                            jtag_intf_i_phy_tms <= 1'b0;
                            jtag_intf_i_phy_tdi <= 1'b0;
                            state               <= (state == ST_INIT) ? ST_IDLE : ST_RESP;
                        end else begin
                            step                <= step_nxt;
                            jtag_intf_i_phy_tms <= tms_at(step_nxt, is_rst_q, is_ir_q, len_q);
                            if (in_shift(step_nxt, is_rst_q, is_ir_q, len_q)) begin
                                jtag_intf_i_phy_tdi <= data_sr[0];
                                data_sr             <= data_sr >> 1;
                            end else begin
                                jtag_intf_i_phy_tdi <= 1'b0;
                            end
                        end
                    end
                end
                ST_IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready           <= 1'b0;
                        state               <= ST_SCAN;
                        step                <= '0;
                        is_ir_q             <= cmd_is_ir;
                        is_rst_q            <= (cmd_len == '0);
                        len_q               <= len_clamped;
                        data_sr             <= cmd_data;
                        cap                 <= '0;
                        jtag_intf_i_phy_tms <= 1'b1;
                        jtag_intf_i_phy_tdi <= 1'b0;
                    end else begin
                        cmd_ready <= !rsp_valid;
                    end
                end
                ST_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap >> rsp_shift;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_jtag_master.sv
// tb/tb_phy_jtag_master.sv - scoreboard bench for phy_jtag_master with bypass/stub TDO models
module tb_phy_jtag_master;

    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 32;

    logic               clk = 1'b0;
    logic               rstb = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_is_ir = 1'b0;
    logic [5:0]         cmd_len = 6'd0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [MAX_LEN-1:0] rsp_data;
    logic               tck, tms, tdi, trst_n, tdo;

    int errors = 0;
    int checks = 0;

    logic tdo_mode = 1'b0;
    logic byp = 1'b0;
    logic tms_log[$];
    logic tdi_log[$];

    typedef struct {
        string        name;
        logic [31:0]  data;
        int           ntck;
        logic [63:0]  tms;
        logic [63:0]  tdi;
        int           lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    phy_jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk                    (clk),
        .rstb                   (rstb),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_is_ir              (cmd_is_ir),
        .cmd_len                (cmd_len),
        .cmd_data               (cmd_data),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_data               (rsp_data),
        .jtag_intf_i_phy_tck    (tck),
        .jtag_intf_i_phy_tms    (tms),
        .jtag_intf_i_phy_tdi    (tdi),
        .jtag_intf_i_phy_trst_n (trst_n),
        .jtag_intf_i_phy_tdo    (tdo)
    );

    // 1-bit bypass register; the stub mode ties TDO low.
    always @(posedge tck) byp <= tdi;
    assign tdo = tdo_mode ? byp : 1'b0;

    always @(posedge tck) begin
        tms_log.push_back(tms);
        tdi_log.push_back(tdi);
    end

    function automatic exp_t model(input string name, input logic is_ir, input int len,
                                   input logic [31:0] data, input logic bypass);
        exp_t e;
        int   l;
        int   k;
        e.name = name;
        e.data = '0;
        e.tms  = '0;
        e.tdi  = '0;
        l = (len > MAX_LEN) ? MAX_LEN : len;
        if (l == 0) begin
            e.ntck = 6;
            e.tms  = 64'h1F;
        end else begin
            k = 0;
            e.tms[k] = 1'b1; k++;
            if (is_ir) begin e.tms[k] = 1'b1; k++; end
            e.tms[k] = 1'b0; k++;
            e.tms[k] = 1'b0; k++;
            for (int i = 0; i < l; i++) begin
                e.tms[k] = (i == l - 1);
                e.tdi[k] = data[i];
                k++;
            end
            e.tms[k] = 1'b1; k++;
            e.tms[k] = 1'b0; k++;
            e.ntck = k;
            if (bypass)
                for (int i = 1; i < l; i++) e.data[i] = data[i-1];
        end
        e.lat = 2 * CLK_DIV * e.ntck + 1;
        return e;
    endfunction

    task automatic send_cmd(input string name, input logic is_ir, input int len,
                            input logic [31:0] data, input logic bypass);
        int n;
        sb.push_back(model(name, is_ir, len, data, bypass));
        tdo_mode  = bypass;
        cmd_is_ir = is_ir;
        cmd_len   = 6'(len);
        cmd_data  = data;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: cmd_ready=%b after %0d clks, expected 1", name, cmd_ready, n);
        end
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        tms_log.delete();
        tdi_log.delete();
    endtask

    task automatic wait_rsp();
        int          n;
        exp_t        e;
        logic [63:0] obs_tms;
        logic [63:0] obs_tdi;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: response with no expected entry");
            return;
        end
        e = sb.pop_front();
        obs_tms = '0;
        obs_tdi = '0;
        for (int i = 0; i < tms_log.size() && i < 64; i++) begin
            obs_tms[i] = tms_log[i];
            obs_tdi[i] = tdi_log[i];
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL %s_valid: rsp_valid=%b, expected 1", e.name, rsp_valid);
        end
        checks++;
        if (n !== e.lat) begin
            errors++; $display("FAIL %s_latency: got %0d clks, expected %0d", e.name, n, e.lat);
        end
        checks++;
        if (rsp_data !== e.data) begin
            errors++; $display("FAIL %s_data: got %h, expected %h", e.name, rsp_data, e.data);
        end
        checks++;
        if (tms_log.size() !== e.ntck) begin
            errors++; $display("FAIL %s_ntck: got %0d, expected %0d", e.name, tms_log.size(), e.ntck);
        end
        checks++;
        if (obs_tms !== e.tms) begin
            errors++; $display("FAIL %s_tms: got %h, expected %h", e.name, obs_tms, e.tms);
        end
        checks++;
        if (obs_tdi !== e.tdi) begin
            errors++; $display("FAIL %s_tdi: got %h, expected %h", e.name, obs_tdi, e.tdi);
        end
    endtask

    task automatic handshake(input string name);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL %s_rsp_drop: rsp_valid=%b, expected 0", name, rsp_valid);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL %s_ready_same_cycle: cmd_ready=%b, expected 0", name, cmd_ready);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({tck, tms, tdi, trst_n, cmd_ready, rsp_valid} !== 6'b010000) begin
            errors++;
            $display("FAIL %s_outputs: tck,tms,tdi,trst_n,cmd_ready,rsp_valid=%b, expected 010000",
                     name, {tck, tms, tdi, trst_n, cmd_ready, rsp_valid});
        end
        checks++;
        if (rsp_data !== '0) begin
            errors++; $display("FAIL %s_rsp_data: got %h, expected 0", name, rsp_data);
        end
    endtask

    task automatic release_and_init(input string name);
        int          n;
        logic [63:0] obs_tms;
        @(negedge clk);
        rstb = 1'b1;
        tms_log.delete();
        tdi_log.delete();
        @(posedge clk);
        #1;
        checks++;
        if (trst_n !== 1'b1) begin
            errors++; $display("FAIL %s_trst: trst_n=%b one clk after release, expected 1", name, trst_n);
        end
        n = 0;
        while (cmd_ready !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        obs_tms = '0;
        for (int i = 0; i < tms_log.size() && i < 64; i++) obs_tms[i] = tms_log[i];
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s_ready: cmd_ready=%b, expected 1", name, cmd_ready);
        end
        checks++;
        if (tms_log.size() !== 6) begin
            errors++; $display("FAIL %s_ntck: got %0d, expected 6", name, tms_log.size());
        end
        checks++;
        if (obs_tms !== 64'h1F) begin
            errors++; $display("FAIL %s_tms: got %h, expected %h", name, obs_tms, 64'h1F);
        end
        checks++;
        if (tck !== 1'b0) begin
            errors++; $display("FAIL %s_tck_idle: tck=%b, expected 0", name, tck);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        release_and_init("init");
    endtask

    task automatic test_dr_bypass();
        send_cmd("dr8", 1'b0, 8, 32'hA5, 1'b1);
        wait_rsp();
        handshake("dr8");
    endtask

    task automatic test_ir_stub();
        send_cmd("ir5", 1'b1, 5, 32'h1F, 1'b0);
        wait_rsp();
        handshake("ir5");
    endtask

    task automatic test_back_pressure();
        exp_t e;
        send_cmd("bp_first", 1'b0, 6, 32'h2D, 1'b1);
        e = model("bp_first", 1'b0, 6, 32'h2D, 1'b1);
        wait_rsp();
        sb.push_back(model("bp_second", 1'b0, 10, 32'h2F1, 1'b1));
        cmd_is_ir = 1'b0;
        cmd_len   = 6'd10;
        cmd_data  = 32'h2F1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== e.data || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: rsp_valid=%b rsp_data=%h cmd_ready=%b, expected 1 %h 0",
                         i, rsp_valid, rsp_data, cmd_ready, e.data);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake: rsp_valid=%b cmd_ready=%b, expected 0 0", rsp_valid, cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_rise: cmd_ready=%b, expected 1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        tms_log.delete();
        tdi_log.delete();
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept: cmd_ready=%b, expected 0", cmd_ready);
        end
        wait_rsp();
        handshake("bp_second");
    endtask

    task automatic test_boundaries();
        logic [31:0] d;
        send_cmd("len0", 1'b0, 0, 32'hFFFF_FFFF, 1'b1);
        wait_rsp();
        handshake("len0");
        d = $urandom();
        send_cmd("len40", 1'b0, 40, d, 1'b1);
        wait_rsp();
        handshake("len40");
        send_cmd("len1", 1'b0, 1, 32'h1, 1'b1);
        wait_rsp();
        handshake("len1");
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int          l;
        for (int i = 0; i < 4; i++) begin
            d = $urandom();
            l = $urandom_range(2, 32);
            send_cmd("b2b", 1'b0, l, d, 1'b1);
            wait_rsp();
            handshake("b2b");
        end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        send_cmd("mid", 1'b0, 8, 32'h3C, 1'b1);
        n = 0;
        while (tms_log.size() < 4 && n < 4000) begin @(negedge clk); n++; end
        rstb = 1'b0;
        #1;
        check_reset_values("mid_reset");
        if (sb.size() > 0) void'(sb.pop_back());
        release_and_init("mid_init");
        send_cmd("post_reset", 1'b0, 12, 32'hABC, 1'b1);
        wait_rsp();
        handshake("post_reset");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dr_bypass();
        test_ir_stub();
        test_back_pressure();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
